set_host: RTL and testbench
===========================

Name: set_host

Overview:
- On-chip initiator for the SET candidate-count engine; drives the SET request side that the current bench drives by hand.
- Walks a pattern ROM and issues each `central`/`radius` pair to SET.
- Waits for `valid`, then checks `candidate` against the expected value and accumulates pass/fail status.
- Sits beside SET in the self-test wrapper; pattern ROM and SET are external.

Parameters:
- NUM_PAT, 64, number of patterns per run (1..2^PAT_AW)
- PAT_AW, 6, pattern address width
- MAX_ERR, 10, error count that aborts the run; 0 = never abort
- TIMEOUT, 20000, max cycles waiting for `busy` low or for `valid`, per pattern

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a run; ignored unless idle
- mode_sel  in  2  SET mode for the run (00 single, 01 union, 10 difference, 11 intersection)
- pat_rd  out  1  ROM read strobe
- pat_addr  out  PAT_AW  ROM address
- pat_central  in  24  ROM data; valid exactly 1 cycle after pat_rd
- pat_radius  in  12  ROM data; same timing
- pat_expected  in  8  ROM data; same timing
- en  out  1  SET request, high exactly one cycle per pattern
- central  out  24  to SET, held from ISSUE until next ISSUE
- radius  out  12  to SET, same hold
- mode  out  2  to SET, latched at start, stable for the whole run
- busy  in  1  from SET
- valid  in  1  from SET
- candidate  in  8  from SET, sampled on the cycle valid=1
- running  out  1  high from start accept to DONE
- done  out  1  one-cycle pulse at run end
- err_cnt  out  7  mismatches this run, saturating at 127
- first_fail  out  PAT_AW  index of first mismatch; 0 if none
- abort  out  1  run ended by MAX_ERR or timeout; held until next start
- timeout  out  1  abort cause was timeout; held until next start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pattern index k=0.
- States and transitions:
  - IDLE: on start=1, clear err_cnt, first_fail, abort, timeout; latch mode=mode_sel; k=0; go to FETCH.
  - FETCH: pat_rd=1, pat_addr=k for one cycle; go to LOAD.
  - LOAD: register pat_central, pat_radius, pat_expected; go to WAIT_IDLE.
  - WAIT_IDLE: stay while busy=1. When busy=0 is sampled, go to ISSUE.
  - ISSUE: en=1 for this cycle only; central/radius driven from the LOAD registers; clear watchdog; go to WAIT_VALID.
  - WAIT_VALID: stay until valid=1. On that edge, capture candidate and go to CHECK.
  - CHECK: if captured candidate != expected: increment err_cnt; record first_fail if err_cnt was 0. Then:
    - if err_cnt reaches MAX_ERR (MAX_ERR≠0): set abort, go to DONE;
    - else if k==NUM_PAT-1: go to DONE;
    - else k=k+1, go to FETCH.
  - DONE: pulse done, drop running; go to IDLE.
- Minimum latency per pattern: 5 cycles + SET response time.
- Watchdog: counts cycles in WAIT_IDLE and in WAIT_VALID. At TIMEOUT cycles it sets abort=1, timeout=1 and goes to DONE.
- Input handling:
  - valid outside WAIT_VALID is ignored.
  - valid in the same cycle as ISSUE is ignored; SET needs ≥1 cycle.
  - start while running is ignored.
- Comparison is exact over 8 bits; X/Z handling is the bench's concern.
- rst_n asserted mid-run: immediate return to IDLE, all outputs to reset values, no done pulse.

Optional Feature:
- Macro: SET_HOST_LOG_EN.
- Defined: adds ports `log_we` (out 1), `log_addr` (out PAT_AW) and `log_data` (out 8).
  - In CHECK, pulses log_we with log_addr=k and log_data=captured candidate, for every pattern, pass or fail.
- Undefined: ports absent, no extra logic; all other behaviour identical.

Decomposition:
- Package set_host_pkg holds:
  - FSM state enum (IDLE, FETCH, LOAD, WAIT_IDLE, ISSUE, WAIT_VALID, CHECK, DONE);
  - mode encodings MODE_SINGLE/UNION/DIFF/INTER;
  - field widths CENTRAL_W=24, RADIUS_W=12, CAND_W=8.
- One sub-module, set_host_wdog: loadable cycle counter with clear and a terminal-count flag.
- Everything else stays in set_host.

Test Plan:
- Pass run: ROM of 4 patterns, NUM_PAT=4, SET model returns expected after 3 cycles → 4 en pulses, each one cycle wide; done after last CHECK; err_cnt=0; abort=0.
- Mismatches: patterns 2 and 5 return candidate+1, NUM_PAT=8 → err_cnt=2, first_fail=2, abort=0.
- Error abort: MAX_ERR=3, every pattern wrong → done after pattern 2; abort=1, timeout=0, err_cnt=3.
- Busy hold: SET holds busy=1 for 50 cycles before pattern 1 → no en until the cycle after busy=0 is sampled; central/radius equal ROM[1].
- Timeout and input hygiene: valid never asserted, TIMEOUT=100 → done exactly 100 cycles after entering WAIT_VALID; abort=1, timeout=1. Spurious valid pulse in IDLE → no state change.
- Reset mid-run: rst_n low during WAIT_VALID of pattern 3 → all outputs 0 immediately. A new start then runs from k=0 with mode re-latched (set mode_sel=2'b11 → mode=3).

Source files
------------

// File: rtl/set_host_pkg.sv
// set_host_pkg: shared types and widths for the SET self-test host.
// FSM state encoding, SET mode encodings and the saturating error increment.
package set_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_IDLE,
    ISSUE,
    WAIT_VALID,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_UNION  = 2'b01;
  localparam logic [1:0] MODE_DIFF   = 2'b10;
  localparam logic [1:0] MODE_INTER  = 2'b11;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int CAND_W    = 8;
  localparam int ERR_W     = 7;

  function automatic logic [ERR_W-1:0] sat_inc(
    input logic [ERR_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/set_host_wdog.sv
// set_host_wdog: watchdog cycle counter with sync clear.
// tc goes high once LIMIT counted cycles have been seen.
module set_host_wdog #(
  parameter int LIMIT = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  // counter freezes at terminal count so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/set_host.sv
// set_host: replays a pattern ROM through SET and scores the candidates.
// Optional result log ports enabled by `define SET_HOST_LOG_EN.
module set_host
  import set_host_pkg::*;
#(
  parameter int NUM_PAT = 64,
  parameter int PAT_AW  = 6,
  parameter int MAX_ERR = 10,
  parameter int TIMEOUT = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode_sel,
  output logic                 pat_rd,
  output logic [PAT_AW-1:0]    pat_addr,
  input  logic [CENTRAL_W-1:0] pat_central,
  input  logic [RADIUS_W-1:0]  pat_radius,
  input  logic [CAND_W-1:0]    pat_expected,
  output logic                 en,
  output logic [CENTRAL_W-1:0] central,
  output logic [RADIUS_W-1:0]  radius,
  output logic [1:0]           mode,
  input  logic                 busy,
  input  logic                 valid,
  input  logic [CAND_W-1:0]    candidate,
  output logic                 running,
  output logic                 done,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [PAT_AW-1:0]    first_fail,
  output logic                 abort,
  output logic                 timeout
`ifdef SET_HOST_LOG_EN
  ,
  output logic                 log_we,
  output logic [PAT_AW-1:0]    log_addr,
  output logic [CAND_W-1:0]    log_data
`endif
);

  state_t state, state_nxt;

  logic [PAT_AW-1:0]    k;
  logic [CENTRAL_W-1:0] ld_central, cen_q;
  logic [RADIUS_W-1:0]  ld_radius, rad_q;
  logic [CAND_W-1:0]    ld_exp, cand_q;
  logic [ERR_W-1:0]     err_nxt;

  logic wd_tc, wd_clr, wd_en;
  logic start_acc, cap, to_hit;
  logic mismatch, last, hit_max;

  assign start_acc = (state == IDLE) && start;
  assign cap       = (state == WAIT_VALID) && valid;
  assign to_hit    = wd_tc &&
                     (((state == WAIT_IDLE) && busy) ||
                      ((state == WAIT_VALID) && !valid));

  assign mismatch = (cand_q != ld_exp);
  assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;
  assign last     = (k == PAT_AW'(NUM_PAT - 1));
  assign hit_max  = (MAX_ERR != 0) && (int'(err_nxt) >= MAX_ERR);

  assign wd_clr = (state == LOAD) || (state == ISSUE);
  assign wd_en  = (state == WAIT_IDLE) || (state == WAIT_VALID);

  set_host_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = FETCH;
      FETCH:      state_nxt = LOAD;
      LOAD:       state_nxt = WAIT_IDLE;
      WAIT_IDLE: begin
        if (!busy)      state_nxt = ISSUE;
        else if (wd_tc) state_nxt = DONE;
      end
      ISSUE:      state_nxt = WAIT_VALID;
      WAIT_VALID: begin
        if (valid)      state_nxt = CHECK;
        else if (wd_tc) state_nxt = DONE;
      end
      CHECK:      state_nxt = (hit_max || last) ? DONE : FETCH;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      mode       <= MODE_SINGLE;
      ld_central <= '0;
      ld_radius  <= '0;
      ld_exp     <= '0;
      cen_q      <= '0;
      rad_q      <= '0;
      cand_q     <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      abort      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (1'b1)
        start_acc: begin
          k          <= '0;
          mode       <= mode_sel;
          err_cnt    <= '0;
          first_fail <= '0;
          abort      <= 1'b0;
          timeout    <= 1'b0;
        end
        state == LOAD: begin
          ld_central <= pat_central;
          ld_radius  <= pat_radius;
          ld_exp     <= pat_expected;
        end
        state == ISSUE: begin
          cen_q <= ld_central;
          rad_q <= ld_radius;
        end
        cap: cand_q <= candidate;
        state == CHECK: begin
          err_cnt <= err_nxt;
          if (mismatch && err_cnt == '0) first_fail <= k;
          if (hit_max)    abort <= 1'b1;
          else if (!last) k     <= k + 1'b1;
        end
        to_hit: begin
          abort   <= 1'b1;
          timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ISSUE presents the freshly loaded pair; the copy then holds it
  assign en       = (state == ISSUE);
  assign central  = en ? ld_central : cen_q;
  assign radius   = en ? ld_radius : rad_q;
  assign pat_rd   = (state == FETCH);
  assign pat_addr = k;
  assign done     = (state == DONE);
  assign running  = (state != IDLE) && (state != DONE);

`ifdef SET_HOST_LOG_EN
  assign log_we   = (state == CHECK);
  assign log_addr = k;
  assign log_data = cand_q;
`endif

endmodule

// File: tb/tb_set_host.sv
// tb_set_host: randomized self-checking bench for set_host.
// ROM and SET are modelled here; results come from a run-level model.
module tb_set_host;

  localparam int NUM_PAT = 8;
  localparam int PAT_AW  = 6;
  localparam int MAX_ERR = 3;
  localparam int TIMEOUT = 100;
  localparam int DEPTH   = 1 << PAT_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode_sel = 2'b00;
  logic              pat_rd;
  logic [PAT_AW-1:0] pat_addr;
  logic [23:0]       pat_central = '0;
  logic [11:0]       pat_radius = '0;
  logic [7:0]        pat_expected = '0;
  logic              en;
  logic [23:0]       central;
  logic [11:0]       radius;
  logic [1:0]        mode;
  logic              busy = 1'b0;
  logic              valid = 1'b0;
  logic [7:0]        candidate = '0;
  logic              running;
  logic              done;
  logic [6:0]        err_cnt;
  logic [PAT_AW-1:0] first_fail;
  logic              abort;
  logic              timeout;
`ifdef SET_HOST_LOG_EN
  logic              log_we;
  logic [PAT_AW-1:0] log_addr;
  logic [7:0]        log_data;
`endif

  set_host #(
    .NUM_PAT (NUM_PAT),
    .PAT_AW  (PAT_AW),
    .MAX_ERR (MAX_ERR),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode_sel     (mode_sel),
    .pat_rd       (pat_rd),
    .pat_addr     (pat_addr),
    .pat_central  (pat_central),
    .pat_radius   (pat_radius),
    .pat_expected (pat_expected),
    .en           (en),
    .central      (central),
    .radius       (radius),
    .mode         (mode),
    .busy         (busy),
    .valid        (valid),
    .candidate    (candidate),
    .running      (running),
    .done         (done),
    .err_cnt      (err_cnt),
    .first_fail   (first_fail),
    .abort        (abort),
    .timeout      (timeout)
`ifdef SET_HOST_LOG_EN
    ,
    .log_we       (log_we),
    .log_addr     (log_addr),
    .log_data     (log_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // pattern ROM contents
  logic [23:0] rom_c [DEPTH];
  logic [11:0] rom_r [DEPTH];
  logic [7:0]  rom_e [DEPTH];

  // stimulus knobs
  bit bad [DEPTH];
  int hold_before [DEPTH];
  int lat_fix;
  bit no_valid, spur_issue, spur_fetch, spur_idle;

  // run-level expectations
  int exp_issues, exp_err, exp_ff;
  bit exp_abort, exp_to;

  // observation bookkeeping
  int set_k, exp_k, exp_fetch, n_en, n_done, done_cyc, drop_cyc;
  int en_cycs [DEPTH];
  logic [1:0] run_mode;
  bit prev_en;
  int cnt, hold;
  bit rd_d;
  logic [PAT_AW-1:0] rd_a;

  task automatic fill_rom;
    for (int i = 0; i < DEPTH; i++) begin
      rom_c[i] = 24'($urandom);
      rom_r[i] = 12'($urandom);
      rom_e[i] = 8'($urandom);
    end
  endtask

  task automatic clear_stim;
    for (int i = 0; i < DEPTH; i++) begin
      bad[i] = 1'b0;
      hold_before[i] = 0;
    end
    lat_fix = 0;
    no_valid = 1'b0;
    spur_issue = 1'b0;
    spur_fetch = 1'b0;
    spur_idle = 1'b0;
  endtask

  // outcome of a whole run from the pass/fail list alone
  task automatic build_model;
    exp_issues = 0;
    exp_err = 0;
    exp_ff = 0;
    exp_abort = 1'b0;
    exp_to = 1'b0;
    if (no_valid) begin
      exp_issues = 1;
      exp_abort = 1'b1;
      exp_to = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PAT && !exp_abort; i++) begin
        exp_issues = i + 1;
        if (bad[i]) begin
          if (exp_err == 0) exp_ff = i;
          exp_err++;
          if (MAX_ERR != 0 && exp_err >= MAX_ERR) exp_abort = 1'b1;
        end
      end
    end
  endtask

  // ROM: data valid the cycle after pat_rd, garbage otherwise
  always @(negedge clk) begin
    if (rd_d) begin
      pat_central = rom_c[rd_a];
      pat_radius = rom_r[rd_a];
      pat_expected = rom_e[rd_a];
    end else begin
      pat_central = 24'($urandom);
      pat_radius = 12'($urandom);
      pat_expected = 8'($urandom);
    end
    rd_d = rst_n && pat_rd;
    rd_a = pat_addr;
  end

  // SET responder
  always @(negedge clk) begin
    valid = 1'b0;
    if (!rst_n) begin
      cnt = 0;
      hold = 0;
      busy = 1'b0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          busy = 1'b0;
          drop_cyc = cyc;
        end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          valid = 1'b1;
          candidate = rom_e[set_k % DEPTH] + 8'(bad[set_k % DEPTH]);
          set_k++;
          hold = hold_before[set_k % DEPTH];
          busy = (hold > 0);
        end
      end
      if (en) begin
        busy = !no_valid;
        if (!no_valid)
          cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
        if (spur_issue) begin
          valid = 1'b1;
          candidate = rom_e[set_k % DEPTH] ^ 8'h81;
        end
      end
      if ((pat_rd && spur_fetch) || spur_idle) begin
        valid = 1'b1;
        candidate = rom_e[set_k % DEPTH] ^ 8'h5a;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (en) begin
        check("en_width", 32'(prev_en), 0);
        check("issue_in_range", 32'(exp_k < exp_issues), 1);
        check("central", 32'(central), 32'(rom_c[exp_k % DEPTH]));
        check("radius", 32'(radius), 32'(rom_r[exp_k % DEPTH]));
        en_cycs[exp_k % DEPTH] = cyc;
        exp_k++;
        n_en++;
      end else if (running && exp_k > 0) begin
        check("central_hold", 32'(central),
              32'(rom_c[(exp_k - 1) % DEPTH]));
        check("radius_hold", 32'(radius),
              32'(rom_r[(exp_k - 1) % DEPTH]));
      end
      if (pat_rd) begin
        check("pat_addr", 32'(pat_addr), 32'(exp_fetch));
        exp_fetch++;
      end
      if (running) check("mode", 32'(mode), 32'(run_mode));
      if (done) begin
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
        check("first_fail", 32'(first_fail), 32'(exp_ff));
        check("abort", 32'(abort), 32'(exp_abort));
        check("timeout", 32'(timeout), 32'(exp_to));
        check("running_at_done", 32'(running), 0);
        done_cyc = cyc;
        n_done++;
      end
      prev_en = en;
    end
  end

  task automatic check_zero(input string name);
    check({name, "_ctl"},
          32'({pat_rd, en, running, done, abort, timeout, mode, err_cnt}), 0);
    check({name, "_central"}, 32'(central), 0);
    check({name, "_radius"}, 32'(radius), 0);
    check({name, "_addr"}, 32'({pat_addr, first_fail}), 0);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    build_model;
    set_k = 0;
    exp_k = 0;
    exp_fetch = 0;
    n_en = 0;
    n_done = 0;
    run_mode = m;
    @(negedge clk);
    #1;
    start = 1'b1;
    mode_sel = m;
    @(negedge clk);
    #1;
    start = 1'b0;
    mode_sel = 2'($urandom);
  endtask

  task automatic wait_done;
    int i;
    i = 0;
    while (n_done == 0 && i < 4000) begin
      @(negedge clk);
      #2;
      i++;
    end
    if (n_done == 0) begin
      checks++;
      errors++;
      $display("FAIL run_end: no done after %0d cycles", i);
    end
    check("issue_count", 32'(n_en), 32'(exp_issues));
  endtask

  task automatic run(input logic [1:0] m);
    pulse_start(m);
    wait_done;
  endtask

  initial begin
    fill_rom;
    clear_stim;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // clean run, fixed 3-cycle SET latency
    lat_fix = 3;
    run(2'b01);
    check("model_pass_issues", 32'(exp_issues), 8);
    for (int i = 0; i < NUM_PAT - 1; i++)
      check("pass_en_spacing", 32'(en_cycs[i + 1] - en_cycs[i]), 8);
    check("pass_done_lat", 32'(done_cyc - en_cycs[NUM_PAT - 1]), 5);

    // patterns 2 and 5 wrong
    clear_stim;
    bad[2] = 1'b1;
    bad[5] = 1'b1;
    run(2'b10);
    check("model_mm_err", 32'(exp_err), 2);
    check("model_mm_ff", 32'(exp_ff), 2);
    check("model_mm_abort", 32'(exp_abort), 0);

    // every pattern wrong: stop at MAX_ERR
    clear_stim;
    for (int i = 0; i < DEPTH; i++) bad[i] = 1'b1;
    run(2'b11);
    check("model_abort_issues", 32'(exp_issues), 3);
    check("model_abort_err", 32'(exp_err), 3);
    check("model_abort_flags", 32'({exp_abort, exp_to}), 32'b10);

    // busy held 50 cycles before pattern 1
    clear_stim;
    lat_fix = 2;
    hold_before[1] = 50;
    run(2'b00);
    check("busy_hold_issue", 32'(en_cycs[1]), 32'(drop_cyc + 1));

    // SET never answers
    clear_stim;
    no_valid = 1'b1;
    run(2'b01);
    check("timeout_latency", 32'(done_cyc - en_cycs[0]), TIMEOUT + 1);
    check("model_to", 32'({exp_abort, exp_to}), 32'b11);

    // stray valid while idle
    @(negedge clk);
    #1;
    spur_idle = 1'b1;
    @(negedge clk);
    #1;
    spur_idle = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      check("idle_quiet", 32'({running, en, done, pat_rd}), 0);
    end
    check("idle_flags_held", 32'({abort, timeout, err_cnt}), 32'h180);

    // stray valid during ISSUE and FETCH
    clear_stim;
    spur_issue = 1'b1;
    spur_fetch = 1'b1;
    run(2'($urandom));

    // reset during WAIT_VALID of pattern 3
    clear_stim;
    lat_fix = 6;
    pulse_start(2'b10);
    for (int i = 0; i < 2000 && n_en < 4; i++) begin
      @(negedge clk);
      #2;
    end
    check("midrun_reached", 32'(n_en), 4);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("reset_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    clear_stim;
    run(2'b11);
    check("mode_relatched", 32'(mode), 3);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      clear_stim;
      fill_rom;
      for (int i = 0; i < DEPTH; i++) begin
        bad[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0)
          hold_before[i] = int'($urandom_range(1, 12));
      end
      spur_issue = 1'($urandom);
      spur_fetch = 1'($urandom);
      run(2'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
